// File: rtl/laser_trigger_gen.sv
// laser_trigger_gen
// Programmable pulse-train generator for the laser trigger line. It emits
// pulses at a programmable period and high time, either as a finite burst
// or continuously. The new period and width can be staged in a shadow
// register and take effect at the next period boundary.
//
// Ports
//   Clk        system clock; all logic is in this domain
//   Reset      synchronous, active-high reset
//   Start      strobe; begins a train when idle and the Period/Width pair is valid
//   Stop       strobe; aborts a running train (wins over Start)
//   Reload     strobe; stages Period/Width for the next period boundary
//   Period     clocks per pulse period (>= 2)
//   Width      clocks of Trigger high (1 .. Period-1)
//   Burst      pulses per train, 0 = continuous
//   Trigger    registered laser trigger
//   Busy       high while a train is running
//   Done       one-cycle pulse when a burst completes normally
//   ConfigErr  one-cycle pulse when a Start or Reload is rejected
//   PulseCount pulses emitted since the last accepted Start
module laser_trigger_gen #(
  parameter int CLK_RATE = 50000000,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Reload,
  input  logic [CNT_W-1:0] Period,
  input  logic [CNT_W-1:0] Width,
  input  logic [CNT_W-1:0] Burst,
  output logic             Trigger,
  output logic             Busy,
  output logic             Done,
  output logic             ConfigErr,
  output logic [CNT_W-1:0] PulseCount
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // CLK_RATE only documents the clock the pulse timing is referenced to;
  // this empty block exists solely to anchor it, it generates no hardware.
  if (CLK_RATE < 1) begin : g_clk_rate_unset
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Period >= 2 and 1 <= width < period, unsigned compares only.
  function automatic logic pair_valid(input logic [CNT_W-1:0] per,
                                      input logic [CNT_W-1:0] wid);
    return (per > ONE) && (wid != ZERO) && (wid < per);
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] ph_r,    ph_s;     // phase within the current period
  logic [CNT_W-1:0] p_r,     p_s;      // active period
  logic [CNT_W-1:0] w_r,     w_s;      // active width
  logic [CNT_W-1:0] b_r,     b_s;      // burst target
  logic [CNT_W-1:0] ps_r,    ps_s;     // shadow period
  logic [CNT_W-1:0] ws_r,    ws_s;     // shadow width
  logic             pend_r,  pend_s;   // shadow waiting for a boundary
  logic             trig_r,  trig_s;
  logic             busy_r,  busy_s;
  logic             done_r,  done_s;
  logic             cerr_r,  cerr_s;
  logic [CNT_W-1:0] cnt_r,   cnt_s;
  logic             pair_ok_s;

  // State and datapath registers; Reset overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      ph_r    <= ZERO;
      p_r     <= ZERO;
      w_r     <= ZERO;
      b_r     <= ZERO;
      ps_r    <= ZERO;
      ws_r    <= ZERO;
      pend_r  <= 1'b0;
      trig_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cerr_r  <= 1'b0;
      cnt_r   <= ZERO;
    end else begin
      state_r <= state_s;
      ph_r    <= ph_s;
      p_r     <= p_s;
      w_r     <= w_s;
      b_r     <= b_s;
      ps_r    <= ps_s;
      ws_r    <= ws_s;
      pend_r  <= pend_s;
      trig_r  <= trig_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cerr_r  <= cerr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_s   = state_r;
    ph_s      = ph_r;
    p_s       = p_r;
    w_s       = w_r;
    b_s       = b_r;
    ps_s      = ps_r;
    ws_s      = ws_r;
    pend_s    = pend_r;
    trig_s    = trig_r;
    cnt_s     = cnt_r;
    done_s    = 1'b0;
    cerr_s    = 1'b0;
    pair_ok_s = pair_valid(Period, Width);

    case (state_r)
      ST_IDLE: begin
        trig_s = 1'b0;
        if (Start && !Stop) begin
          if (pair_ok_s) begin
            // Start latches its own inputs, so any staged reload is dropped.
            p_s     = Period;
            w_s     = Width;
            b_s     = Burst;
            ph_s    = ZERO;
            trig_s  = 1'b1;
            cnt_s   = ONE;
            pend_s  = 1'b0;
            state_s = ST_RUN;
          end else begin
            cerr_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (Stop) begin
          trig_s  = 1'b0;
          pend_s  = 1'b0;
          state_s = ST_IDLE;
        end else if (ph_r < (p_r - ONE)) begin
          ph_s   = ph_r + ONE;
          trig_s = (ph_r + ONE) < w_r;
        end else if ((b_r != ZERO) && (cnt_r == b_r)) begin
          trig_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          // Period boundary: next pulse starts; in continuous mode the
          // count simply wraps.
          ph_s   = ZERO;
          trig_s = 1'b1;
          cnt_s  = cnt_r + ONE;
          if (pend_r) begin
            p_s    = ps_r;
            w_s    = ws_r;
            pend_s = 1'b0;
          end else begin
            pend_s = 1'b0;
          end
        end
      end

      default: begin
        trig_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase

    // Reload is evaluated last so a Reload landing on a boundary cycle
    // stages the new shadow for the following boundary.
    if (Reload) begin
      if (pair_ok_s) begin
        ps_s   = Period;
        ws_s   = Width;
        pend_s = 1'b1;
      end else begin
        cerr_s = 1'b1;
      end
    end else begin
      ps_s = ps_s;
    end

    busy_s = (state_s == ST_RUN);
  end

  assign Trigger    = trig_r;
  assign Busy       = busy_r;
  assign Done       = done_r;
  assign ConfigErr  = cerr_r;
  assign PulseCount = cnt_r;

endmodule

// File: tb/tb_laser_trigger_gen.sv
// Scoreboard bench for laser_trigger_gen. Stimulus pushes hand-computed
// expected events (Trigger edges, Done, ConfigErr) into a time-ordered
// queue; a monitor forked from the same block pops and compares them as
// the DUT presents them.
module tb_laser_trigger_gen;

  localparam int CNT_W    = 32;
  localparam int CLK_RATE = 1000;

  logic             Clk = 1'b0;
  logic             Reset, Start, Stop, Reload;
  logic [CNT_W-1:0] Period, Width, Burst;
  logic             Trigger, Busy, Done, ConfigErr;
  logic [CNT_W-1:0] PulseCount;

  laser_trigger_gen #(.CLK_RATE(CLK_RATE), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Reload(Reload),
    .Period(Period), .Width(Width), .Burst(Burst),
    .Trigger(Trigger), .Busy(Busy), .Done(Done), .ConfigErr(ConfigErr),
    .PulseCount(PulseCount)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_DONE = 2, EV_CERR = 3} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  logic gate_on  = 1'b0;
  int   rate_cnt = 0;

  function automatic void push_ev(input ev_kind_t k, input int c, input int pc);
    ev_t e;
    int  idx;
    bit  found;
    e.kind = k;
    e.cyc  = c;
    e.pc   = pc;
    idx    = exp_q.size();
    found  = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (!found && ((exp_q[i].cyc > c) || ((exp_q[i].cyc == c) && (exp_q[i].kind > k)))) begin
        idx   = i;
        found = 1'b1;
      end
    end
    exp_q.insert(idx, e);
  endfunction

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: got %s cyc=%0d pc=%0d, required no event", k.name(), cyc, PulseCount);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (e.cyc != cyc) || (e.pc != PulseCount)) begin
        failures++;
        $display("FAIL event: got %s cyc=%0d pc=%0d, required %s cyc=%0d pc=%0d",
                 k.name(), cyc, PulseCount, e.kind.name(), e.cyc, e.pc);
      end
    end
  endtask

  task automatic monitor_loop();
    logic prev_trig;
    ev_t  e;
    prev_trig = 1'b0;
    forever begin
      @(negedge Clk);
      while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_event: got nothing, required %s cyc=%0d pc=%0d",
                 e.kind.name(), e.cyc, e.pc);
      end
      if (Trigger === 1'b1 && prev_trig == 1'b0) check_ev(EV_RISE);
      if (Trigger === 1'b0 && prev_trig == 1'b1) check_ev(EV_FALL);
      if (Done === 1'b1) check_ev(EV_DONE);
      if (ConfigErr === 1'b1) check_ev(EV_CERR);
      // Loopback rate counter: rising edges inside the gate window.
      if (gate_on && Trigger === 1'b1 && prev_trig == 1'b0) rate_cnt++;
      prev_trig = (Trigger === 1'b1);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Entered #1 after an edge; strobes are sampled on the next edge.
  task automatic strobe(input logic st, input logic sp, input logic rl,
                        input int per, input int wid, input int bur);
    Start  = st;
    Stop   = sp;
    Reload = rl;
    Period = per;
    Width  = wid;
    Burst  = bur;
    @(posedge Clk);
    #1;
    Start  = 1'b0;
    Stop   = 1'b0;
    Reload = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s2;
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Reload = 1'b0;
    Period = 0; Width = 0; Burst = 0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("reset_trigger", Trigger, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_cfgerr", ConfigErr, 0);
    chk("reset_pulsecount", PulseCount, 0);

    // Burst of 4: P=10, W=3.
    s = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      push_ev(EV_RISE, s + 10 * i, i + 1);
      push_ev(EV_FALL, s + 10 * i + 3, i + 1);
    end
    push_ev(EV_DONE, s + 40, 4);
    strobe(1'b1, 1'b0, 1'b0, 10, 3, 4);
    Period = 7; Width = 6; Burst = 1;   // ignored without Reload
    wait_to(s + 20);
    chk("burst_busy_mid", Busy, 1);
    wait_to(s + 40);
    chk("burst_busy_end", Busy, 0);
    chk("burst_pulsecount", PulseCount, 4);
    wait_to(s + 43);
    chk("burst_pulsecount_hold", PulseCount, 4);

    // Rejected Starts.
    push_ev(EV_CERR, cyc + 1, 4);
    strobe(1'b1, 1'b0, 1'b0, 10, 0, 0);
    push_ev(EV_CERR, cyc + 1, 4);
    strobe(1'b1, 1'b0, 1'b0, 5, 5, 0);
    push_ev(EV_CERR, cyc + 1, 4);
    strobe(1'b1, 1'b0, 1'b0, 1, 1, 0);
    wait_to(cyc + 1);
    chk("bad_start_busy", Busy, 0);
    chk("bad_start_trigger", Trigger, 0);
    chk("bad_start_pulsecount", PulseCount, 4);

    // Continuous P=4, W=1; Stop sampled 100 cycles after the first rise.
    s = cyc + 1;
    for (int i = 0; i < 25; i++) begin
      push_ev(EV_RISE, s + 4 * i, i + 1);
      push_ev(EV_FALL, s + 4 * i + 1, i + 1);
    end
    strobe(1'b1, 1'b0, 1'b0, 4, 1, 0);
    wait_to(s + 99);
    strobe(1'b0, 1'b1, 1'b0, 4, 1, 0);
    chk("cont_stop_trigger", Trigger, 0);
    chk("cont_stop_busy", Busy, 0);
    chk("cont_stop_pulsecount", PulseCount, (100 + 3) / 4);
    strobe(1'b1, 1'b1, 1'b0, 4, 1, 0);
    chk("start_stop_busy", Busy, 0);
    chk("start_stop_pulsecount", PulseCount, 25);

    // Reload during pulse 1: P=10,W=5,B=3 then 20/2; invalid reload in between.
    s = cyc + 1;
    push_ev(EV_RISE, s, 1);       push_ev(EV_FALL, s + 5, 1);
    push_ev(EV_RISE, s + 10, 2);  push_ev(EV_FALL, s + 12, 2);
    push_ev(EV_RISE, s + 30, 3);  push_ev(EV_FALL, s + 32, 3);
    push_ev(EV_DONE, s + 50, 3);
    push_ev(EV_CERR, s + 4, 1);
    strobe(1'b1, 1'b0, 1'b0, 10, 5, 3);
    wait_to(s + 1);
    strobe(1'b0, 1'b0, 1'b1, 20, 2, 3);
    wait_to(s + 3);
    strobe(1'b0, 1'b0, 1'b1, 20, 20, 3);
    wait_to(s + 25);
    chk("reload_busy_mid", Busy, 1);
    wait_to(s + 50);
    chk("reload_busy_end", Busy, 0);
    chk("reload_pulsecount", PulseCount, 3);

    // Reset on the second high cycle of a pulse.
    s = cyc + 1;
    push_ev(EV_RISE, s, 1);
    push_ev(EV_FALL, s + 2, 0);
    strobe(1'b1, 1'b0, 1'b0, 10, 4, 0);
    wait_to(s + 1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("midreset_trigger", Trigger, 0);
    chk("midreset_busy", Busy, 0);
    chk("midreset_pulsecount", PulseCount, 0);
    s2 = cyc + 1;
    push_ev(EV_RISE, s2, 1);      push_ev(EV_FALL, s2 + 2, 1);
    push_ev(EV_RISE, s2 + 6, 2);  push_ev(EV_FALL, s2 + 8, 2);
    push_ev(EV_DONE, s2 + 12, 2);
    strobe(1'b1, 1'b0, 1'b0, 6, 2, 2);
    wait_to(s2 + 13);
    chk("post_reset_busy", Busy, 0);
    chk("post_reset_pulsecount", PulseCount, 2);

    // Loopback into a rate counter with a CLK_RATE-cycle gate window.
    s = cyc + 1;
    for (int i = 0; i < 21; i++) push_ev(EV_RISE, s + 50 * i, i + 1);
    for (int i = 0; i < 20; i++) push_ev(EV_FALL, s + 50 * i + 25, i + 1);
    push_ev(EV_FALL, s + 1001, 21);
    strobe(1'b1, 1'b0, 1'b0, 50, 25, 0);
    gate_on = 1'b1;
    wait_to(s + CLK_RATE);
    gate_on = 1'b0;
    strobe(1'b0, 1'b1, 1'b0, 50, 25, 0);
    chk("loopback_rate", rate_cnt, CLK_RATE / 50);
    chk("loopback_stop_busy", Busy, 0);

    repeat (3) @(posedge Clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_trigger_gen.md
Name: laser_trigger_gen

Overview:
- Programmable pulse-train generator. Drives the laser trigger line at a set period and duty, either as a finite burst or continuously.
- It is the source side of the laser-rate measurement path. Its Trigger output can be looped back into the existing rate counter, which should then report CLK_RATE / Period pulses per second.
- Configured by control-register logic from the Ethernet server. All logic is in the Clk domain.

Parameters:
- CLK_RATE, 50000000, system clock frequency in Hz. Used for documentation and bench checks only; no logic depends on it.
- CNT_W, 32, width of the Period, Width, Burst and PulseCount fields.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle strobe; begins a pulse train when idle.
- Stop  in  1  single-cycle strobe; aborts the train.
- Reload  in  1  single-cycle strobe; captures Period/Width into a shadow register for on-the-fly update.
- Period  in  CNT_W  clocks per pulse period. Valid range is 2 or more.
- Width  in  CNT_W  clocks of Trigger high. Valid range is 1 to Period-1.
- Burst  in  CNT_W  number of pulses to emit; 0 means continuous.
- Trigger  out  1  registered laser trigger.
- Busy  out  1  high while a train is running.
- Done  out  1  one-cycle pulse when a burst completes normally.
- ConfigErr  out  1  one-cycle pulse when a Start or Reload is rejected.
- PulseCount  out  CNT_W  pulses emitted since the last accepted Start.

Behaviour:
- Interface (already decided): one clock, Clk. Reset is synchronous and active-high. On Reset all outputs go to 0 at the next edge: Trigger, Busy, Done, ConfigErr, PulseCount. Internal state returns to IDLE and the pending-reload flag is cleared. Reset overrides all other inputs, including mid-pulse.
- States:
  - IDLE: Trigger=0, Busy=0.
  - RUN: Busy=1.
- Internal registers: phase counter Ph (CNT_W), active period P, active width W, burst target B, shadow period Ps, shadow width Ws, pending flag.
- Validity test, applied to a (Period, Width) pair: Period >= 2 and 1 <= Width < Period. Use unsigned compares only.
- IDLE, Start=1, Stop=0, pair valid:
  - Latch P=Period, W=Width, B=Burst.
  - Set Ph=0, Trigger=1, PulseCount=1, Busy=1; go to RUN.
  - Trigger first rises the cycle after Start is sampled.
- IDLE, Start=1, pair invalid: ConfigErr=1 for one cycle; remain in IDLE with outputs unchanged.
- Start while in RUN is ignored: no error, no restart.
- Stop has priority over Start in the same cycle. In RUN, Stop sets Trigger=0 and Busy=0 at the next edge and returns to IDLE. Done is not asserted, PulseCount holds, and any pending reload is cleared.
- RUN, when Ph < P-1:
  - Ph <= Ph+1.
  - Trigger <= (Ph+1 < W).
  - Pulse shape: high for exactly W cycles, low for P-W cycles.
- RUN, period boundary (Ph == P-1):
  - If B != 0 and PulseCount == B: go to IDLE with Trigger=0, Busy=0, and Done=1 for one cycle. PulseCount holds its final value.
  - Otherwise: Ph <= 0, Trigger <= 1, PulseCount <= PulseCount+1. If the pending flag is set, load P=Ps and W=Ws and clear the flag.
- Reload:
  - Samples Period/Width in any state.
  - Valid pair: write Ps/Ws and set pending. A second Reload before the boundary overwrites the shadow; last one wins.
  - Invalid pair: ConfigErr=1 for one cycle; shadow and pending are unchanged.
  - In IDLE, a valid Reload is discarded at the next Start, because Start latches its own inputs.
- Continuous mode (B=0): PulseCount wraps from 2^CNT_W-1 to 0 with no other effect.
- Changes to the Period/Width/Burst inputs while in RUN have no effect without Reload. Burst is never reloaded mid-train.
- Done and ConfigErr can assert in the same cycle, e.g. when an invalid Reload coincides with burst completion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then Start with Period=10, Width=3, Burst=4:
  - Trigger is high 3 cycles and low 7 cycles, four times. The first rise is 1 cycle after Start.
  - Done pulses once, 40 cycles after the first rise; Busy then falls.
  - PulseCount reads 1, 2, 3, 4 and holds 4.
- Start with Width=0, then Start with Width=Period=5, then Start with Period=1, Width=1:
  - Each produces a single-cycle ConfigErr.
  - Busy and Trigger stay 0; PulseCount is unchanged.
- Burst=0, Period=4, Width=1, run 100 cycles from the first rise, then Stop:
  - Exactly 25 single-cycle pulses.
  - Trigger=0 and Busy=0 one cycle after Stop; Done is never asserted; PulseCount=25 or 26 per the Stop cycle, checked against the model.
  - Start and Stop in the same cycle from IDLE leaves the block idle.
- Period=10, Width=5, Burst=3; Reload with Period=20, Width=2 during pulse 1:
  - Pulse 1 is still 10 cycles with 5 high.
  - Pulses 2 and 3 are 20 cycles with 2 high.
  - An invalid Reload (Width=20) gives ConfigErr and leaves the shape unchanged.
- Reset asserted on the 2nd high cycle of a pulse:
  - Next edge: Trigger=0, Busy=0, PulseCount=0.
  - A later valid Start works normally.
- Loopback into the rate counter with a reduced CLK_RATE bench setting of 1000, Period=50, Width=25, Burst=0: the counter reports 20 per gate window.
